// File: rtl/flight_cmd_sequencer.sv
// Command sequencer driving the shared one-hot mode/position selectors for the axis datapath.
// Accepts CLEAR/ATTACK/DEFENSE/STEALTH/WARP commands and enforces a warp cooldown.
module flight_cmd_sequencer #(
  parameter int unsigned LEN_W         = 8,
  parameter int unsigned WARP_COOLDOWN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_abort,
  output logic [3:0]       mode_selector,
  output logic [3:0]       pos_selector,
  output logic             done,
  output logic             err,
  output logic             cooldown_active
);

  localparam int unsigned CD_W = $clog2(WARP_COOLDOWN + 1);

  localparam logic [3:0] MODE_ZERO = 4'b0001;
  localparam logic [3:0] POS_CLEAR = 4'b0001;
  localparam logic [3:0] POS_INTG  = 4'b0010;
  localparam logic [3:0] POS_WARP  = 4'b0100;

  typedef enum logic [1:0] {
    S_ZERO,
    S_IDLE,
    S_RUN,
    S_WARP
  } state_t;

  typedef enum logic [2:0] {
    OP_CLEAR   = 3'd0,
    OP_ATTACK  = 3'd1,
    OP_DEFENSE = 3'd2,
    OP_STEALTH = 3'd3,
    OP_WARP    = 3'd4
  } op_t;

  state_t           r_state, w_state;
  logic [3:0]       r_mode, w_mode;
  logic [LEN_W-1:0] r_run_cnt, w_run_cnt;
  logic [CD_W-1:0]  r_cd_cnt, w_cd_cnt;
  logic             w_done, w_err;
  logic [3:0]       w_mode_sel, w_pos_sel;

  always_comb begin
    w_state   = r_state;
    w_mode    = r_mode;
    w_run_cnt = r_run_cnt;
    w_cd_cnt  = (r_cd_cnt != '0) ? r_cd_cnt - 1'b1 : '0;
    w_done    = 1'b0;
    w_err     = 1'b0;

    case (r_state)
      S_ZERO: w_state = S_IDLE;
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLEAR: w_state = S_ZERO;
            OP_ATTACK, OP_DEFENSE, OP_STEALTH: begin
              w_state   = S_RUN;
              w_run_cnt = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
              w_mode    = 4'b0001 << cmd_op;
            end
            OP_WARP: begin
              if (r_cd_cnt != '0) begin
                w_err = 1'b1;
              end else begin
                w_state  = S_WARP;
                w_cd_cnt = CD_W'(WARP_COOLDOWN);
              end
            end
            default: w_err = 1'b1;
          endcase
        end
      end
      S_RUN: begin
        // abort takes priority over a coinciding final count
        if (cmd_abort) begin
          w_state = S_IDLE;
        end else if (r_run_cnt <= LEN_W'(1)) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
        end else begin
          w_run_cnt = r_run_cnt - 1'b1;
        end
      end
      S_WARP:  w_state = S_IDLE;
      default: w_state = S_ZERO;
    endcase

    // outputs are decoded from the next state so they can be registered
    w_mode_sel = MODE_ZERO;
    w_pos_sel  = POS_INTG;
    case (w_state)
      S_ZERO:  w_pos_sel  = POS_CLEAR;
      S_RUN:   w_mode_sel = w_mode;
      S_WARP:  w_pos_sel  = POS_WARP;
      default: w_pos_sel  = POS_INTG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_ZERO;
      r_mode          <= MODE_ZERO;
      r_run_cnt       <= '0;
      r_cd_cnt        <= '0;
      cmd_ready       <= 1'b0;
      mode_selector   <= MODE_ZERO;
      pos_selector    <= POS_CLEAR;
      done            <= 1'b0;
      err             <= 1'b0;
      cooldown_active <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_mode          <= w_mode;
      r_run_cnt       <= w_run_cnt;
      r_cd_cnt        <= w_cd_cnt;
      cmd_ready       <= (w_state == S_IDLE);
      mode_selector   <= w_mode_sel;
      pos_selector    <= w_pos_sel;
      done            <= w_done;
      err             <= w_err;
      cooldown_active <= (w_cd_cnt != '0);
    end
  end

endmodule

// File: tb/tb_flight_cmd_sequencer.sv
// Self-checking bench: timestamp-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_flight_cmd_sequencer;

  localparam int unsigned LEN_W = 8;
  localparam int unsigned CD    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_abort = 1'b0;
  logic [3:0]       mode_selector;
  logic [3:0]       pos_selector;
  logic             done;
  logic             err;
  logic             cooldown_active;

  flight_cmd_sequencer #(
    .LEN_W(LEN_W),
    .WARP_COOLDOWN(CD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_len(cmd_len),
    .cmd_abort(cmd_abort),
    .mode_selector(mode_selector),
    .pos_selector(pos_selector),
    .done(done),
    .err(err),
    .cooldown_active(cooldown_active)
  );

  always #5 clk = ~clk;

  // Model: cycle c is the interval following rising edge c. Activity is kept
  // as timestamps: cycle of ZERO, span of the RUN interval, WARP cycle, pulses.
  int         cyc        = 0;
  int         zero_cycle = 0;
  int         run_s      = 0;
  int         run_e      = -1;
  int         warp_cycle = -100;
  int         done_cycle = -1;
  int         err_cycle  = -1;
  logic [3:0] m_mode     = 4'b0001;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic bit m_zero(int c);
    return c == zero_cycle;
  endfunction
  function automatic bit m_run(int c);
    return (c >= run_s) && (c <= run_e);
  endfunction
  function automatic bit m_warp(int c);
    return c == warp_cycle;
  endfunction
  function automatic bit m_ready(int c);
    return !m_zero(c) && !m_run(c) && !m_warp(c);
  endfunction
  function automatic bit m_cd(int c);
    return (c >= warp_cycle) && (c < warp_cycle + int'(CD));
  endfunction

  initial begin
    int p, t, len;
    forever begin
      @(posedge clk);
      p = cyc;
      t = cyc + 1;
      if (rst) begin
        zero_cycle = t;
        run_s      = 0;
        run_e      = -1;
        warp_cycle = -100;
        done_cycle = -1;
        err_cycle  = -1;
      end else begin
        if (m_run(p) && cmd_abort) begin
          run_e      = p;
          done_cycle = -1;
        end
        if (m_ready(p) && cmd_valid) begin
          case (cmd_op)
            3'd0: zero_cycle = t;
            3'd1, 3'd2, 3'd3: begin
              len        = (cmd_len == 0) ? 1 : int'(cmd_len);
              run_s      = t;
              run_e      = t + len - 1;
              done_cycle = t + len;
              m_mode     = (cmd_op == 3'd1) ? 4'b0010 :
                           (cmd_op == 3'd2) ? 4'b0100 : 4'b1000;
            end
            3'd4: begin
              if (m_cd(p)) err_cycle = t;
              else warp_cycle = t;
            end
            default: err_cycle = t;
          endcase
        end
      end
      cyc = t;
    end
  end

  task automatic tick();
    logic [14:0] exp_v, act_v;
    @(negedge clk);
    exp_v = {m_run(cyc) ? m_mode : 4'b0001,
             m_zero(cyc) ? 4'b0001 : (m_warp(cyc) ? 4'b0100 : 4'b0010),
             m_ready(cyc), (cyc == done_cycle), (cyc == err_cycle), m_cd(cyc)};
    act_v = {mode_selector, pos_selector, cmd_ready, done, err, cooldown_active};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model cycle %0d: got mode=%b pos=%b rdy=%b done=%b err=%b cd=%b, want mode=%b pos=%b rdy=%b done=%b err=%b cd=%b",
               cyc, act_v[14:11], act_v[10:7], act_v[6], act_v[5], act_v[4], act_v[3],
               exp_v[14:11], exp_v[10:7], exp_v[6], exp_v[5], exp_v[4], exp_v[3]);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [LEN_W-1:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int cnt, dn, axis, done_at, r;

    // reset held for three cycles
    repeat (3) begin
      tick();
      chk("rst_mode", mode_selector, 1);
      chk("rst_pos", pos_selector, 1);
    end
    rst = 1'b0;
    tick();
    chk("first_ready", cmd_ready, 1);
    chk("idle_mode", mode_selector, 1);
    chk("idle_pos", pos_selector, 2);

    // ATTACK len 5 feeding an axis with speed 3
    send(3'd1, 8'd5);
    cnt = 0; dn = 0; axis = 0; done_at = -1;
    for (int i = 0; i < 8; i++) begin
      if (mode_selector == 4'b0010) cnt++;
      if (mode_selector == 4'b0010 && pos_selector == 4'b0010) axis += 3;
      if (done) begin dn++; done_at = i; end
      tick();
    end
    chk("atk_cycles", cnt, 5);
    chk("atk_done_cnt", dn, 1);
    chk("atk_done_at", done_at, 5);
    chk("atk_axis", axis, 15);

    // STEALTH with zero length
    send(3'd3, 8'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (mode_selector == 4'b1000) cnt++;
      tick();
    end
    chk("stealth_cycles", cnt, 1);

    // DEFENSE len 10, abort in its 4th RUN cycle
    send(3'd2, 8'd10);
    cnt = 0; dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (mode_selector == 4'b0100) cnt++;
      if (done) dn++;
      cmd_abort = (i == 3);
      tick();
    end
    cmd_abort = 1'b0;
    chk("def_cycles", cnt, 4);
    chk("def_done_cnt", dn, 0);

    // warp cooldown
    send(3'd4, 8'd0);
    chk("warp1_pos", pos_selector, 4);
    tick();
    chk("post_warp_pos", pos_selector, 2);
    chk("post_warp_cd", cooldown_active, 1);
    send(3'd4, 8'd0);
    chk("warp2_err", err, 1);
    chk("warp2_pos", pos_selector, 2);
    tick();
    tick();
    send(3'd4, 8'd0);
    chk("warp3_pos", pos_selector, 4);

    // reset mid-RUN while cooldown still active
    tick();
    send(3'd1, 8'd20);
    chk("run_cd_before", cooldown_active, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_mode", mode_selector, 1);
    chk("midrst_pos", pos_selector, 1);
    chk("midrst_cd", cooldown_active, 0);
    chk("midrst_ready", cmd_ready, 0);
    tick();

    // illegal op
    send(3'd6, 8'd0);
    chk("illegal_err", err, 1);
    chk("illegal_mode", mode_selector, 1);
    chk("illegal_pos", pos_selector, 2);

    // randomized traffic
    repeat (3000) begin
      rst       = ($urandom_range(0, 99) == 0);
      cmd_valid = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      if (r == 0)      cmd_op = 3'd0;
      else if (r <= 2) cmd_op = 3'd1;
      else if (r == 3) cmd_op = 3'd2;
      else if (r == 4) cmd_op = 3'd3;
      else if (r <= 7) cmd_op = 3'd4;
      else             cmd_op = 3'($urandom_range(5, 7));
      cmd_len   = ($urandom_range(0, 3) == 0) ? '0 : LEN_W'($urandom_range(1, 12));
      cmd_abort = ($urandom_range(0, 15) == 0);
      tick();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_abort = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/flight_cmd_sequencer.md
# flight_cmd_sequencer

Command-side controller that drives the one-hot `mode_selector` and `pos_selector` buses consumed by the per-axis position datapath, shared by all three axes. It accepts flight commands over a valid/ready handshake and sequences them into timed velocity-mode intervals, single-cycle warp jumps and position clears. It also enforces a warp cooldown.

## Interface
- `LEN_W`, 8: width of the command duration field.
- `WARP_COOLDOWN`, 16: cycles after a warp during which another warp is refused; must be ≥1.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  3  0 CLEAR, 1 ATTACK, 2 DEFENSE, 3 STEALTH, 4 WARP, 5-7 illegal.
- `cmd_len`  in  LEN_W  number of RUN cycles for ATTACK/DEFENSE/STEALTH; 0 is treated as 1.
- `cmd_abort`  in  1  terminates an active RUN interval.
- `mode_selector`  out  4  one-hot: 0001 zero velocity, 0010 attack, 0100 defense, 1000 stealth.
- `pos_selector`  out  4  one-hot: 0001 clear, 0010 integrate (position + velocity), 0100 warp; 1000 is never driven.
- `done`  out  1  one-cycle pulse when a RUN interval completes normally.
- `err`  out  1  one-cycle pulse when an illegal op, or a WARP during cooldown, is dropped.
- `cooldown_active`  out  1  high while the warp cooldown counter is nonzero.

## Operation
- All outputs are registered. Both selectors are exactly one-hot in every cycle, including during reset.
- States are ZERO, IDLE, RUN and WARP.
- **ZERO**
  - Outputs: `mode_selector`=0001, `pos_selector`=0001, `cmd_ready`=0.
  - Entered on reset and on a CLEAR command.
  - Stays in ZERO while `rst`=1. Otherwise moves to IDLE on the next edge.
- **IDLE**
  - Outputs: `mode_selector`=0001, `pos_selector`=0010, so position holds. `cmd_ready`=1.
  - A command is accepted on an edge where `cmd_valid`=1 and `cmd_ready`=1.
  - CLEAR goes to ZERO.
  - ATTACK, DEFENSE and STEALTH go to RUN. The run counter is loaded with max(`cmd_len`,1), and the mode is latched.
  - WARP goes to WARP if `cooldown_active`=0. Otherwise the command is dropped, `err` pulses, and the state stays IDLE.
  - An illegal op is dropped, `err` pulses, and the state stays IDLE.
- **RUN**
  - Outputs: `mode_selector` = the latched mode, `pos_selector`=0010, `cmd_ready`=0.
  - The counter decrements every cycle.
  - When the counter reaches 1, the state returns to IDLE and `done` pulses, coincident with the first IDLE cycle.
  - If `cmd_abort`=1, the state returns to IDLE on the next edge with no `done`. When abort and the final count coincide, abort wins: no `done`.
- **WARP**
  - Outputs: `mode_selector`=0001, `pos_selector`=0100, `cmd_ready`=0.
  - Lasts exactly one cycle, then returns to IDLE.
  - On entry to WARP, the cooldown counter loads `WARP_COOLDOWN`.
- **Cooldown counter**
  - Decrements once per cycle while nonzero, independent of state.
  - Saturates at 0.
  - `cooldown_active` = (counter ≠ 0).
- `cmd_abort` is ignored outside RUN.
- `cmd_len` is unsigned. The counter is LEN_W bits wide, so there is no wrap.
- **Reset mid-operation:** asserting `rst` in any state goes to ZERO on the next edge. Reset also clears the run counter and the cooldown counter, and deasserts `done` and `err`.

## Timing
- Reset values of the outputs:
  - `mode_selector`=0001, `pos_selector`=0001, `cmd_ready`=0, `done`=0, `err`=0, `cooldown_active`=0.
- **First acceptance:** the first edge after `rst` falls puts the block in IDLE, so `cmd_ready`=1 one cycle after reset is released.
- **Command latency:** a command accepted at edge N is reflected on the selectors from cycle N+1.
- **RUN duration:** max(`cmd_len`,1) cycles. `cmd_ready` returns to 1 in the cycle that `done` pulses.
- **Back-to-back commands:** minimum spacing between accepted commands is `cmd_len`+1 cycles.
- **Warp spacing:** at most one warp per `WARP_COOLDOWN`+1 cycles. The cycle after WARP is IDLE with `cooldown_active`=1.
- **Command holding:** `cmd_ready` does not depend combinationally on `cmd_valid`. A command held while `cmd_ready`=0 is not consumed.

## Test plan
- **Reset:** hold `rst` 3 cycles, then release.
  - During reset: `mode_selector`=0001, `pos_selector`=0001.
  - After release: IDLE with 0001/0010 and `cmd_ready`=1.
- **ATTACK run:** ATTACK, `cmd_len`=5.
  - Exactly 5 cycles of `mode_selector`=0010, `pos_selector`=0010.
  - `done` pulses once, in the first IDLE cycle.
  - A downstream axis starting at 0 with attack speed 3 reads 15.
- **Zero length:** STEALTH, `cmd_len`=0, yields 1 RUN cycle with `mode_selector`=1000. DEFENSE, `cmd_len`=10, with `cmd_abort` in its 4th RUN cycle, returns to IDLE after that cycle with no `done`.
- **Warp cooldown** (`WARP_COOLDOWN`=4):
  - WARP gives one cycle of `pos_selector`=0100.
  - A second WARP 2 cycles later is dropped, with an `err` pulse and no 0100.
  - A WARP 5 cycles after the first is accepted.
- **Illegal op:** `cmd_op`=6 gives an `err` pulse and the selectors stay 0001/0010.
- **Reset mid-RUN:** assert `rst` mid-RUN (`cmd_len`=20). The next cycle is ZERO with 0001/0001, and `cooldown_active`=0.
